// File: rtl/sc_mem_pkg.sv
// ---------------------------------------------------------------------------
// sc_mem_pkg
// Shared definitions for the load/store sequencer: access-size codes, the
// sequencer state encoding and the alignment rule used to reject requests.
// ---------------------------------------------------------------------------
package sc_mem_pkg;

    // Access size codes; 2'b11 is reserved and always rejected.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RMW_READ  = 2'b10,
        RMW_WRITE = 2'b11
    } state_t;

    // A request is rejected when the address is not naturally aligned for its
    // size, or when the size code is the reserved one.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sc_mem_lane.sv
// ---------------------------------------------------------------------------
// sc_mem_lane
// Combinational lane logic for whole-word RAM traffic (little-endian lanes).
// Extracts the addressed byte/half/word from a RAM word and extends it, and
// builds the store word by replacing the addressed lane(s) with store data.
//
// Ports:
//   word      in   32  RAM word being read
//   offset    in   2   byte offset within the word (addr[1:0])
//   size      in   2   access size code
//   sign_ext  in   1   1 = sign-extend the loaded lane, 0 = zero-extend
//   wdata     in   32  store data; only its low byte/half is used for sub-words
//   load_val  out  32  extended load value
//   merged    out  32  word with the store lane(s) replaced
// ---------------------------------------------------------------------------
module sc_mem_lane
    import sc_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        lane_b   = word[{offset, 3'b000} +: 8];
        lane_h   = offset[1] ? word[31:16] : word[15:0];
        load_val = '0;
        merged   = word;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{sign_ext & lane_b[7]}}, lane_b};
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = {{16{sign_ext & lane_h[15]}}, lane_h};
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: begin
                load_val = word;
                merged   = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sc_mem_access_unit.sv
// ---------------------------------------------------------------------------
// sc_mem_access_unit
// Load/store sequencer between the single-cycle datapath and a word-wide,
// synchronous-read data RAM. Word stores complete in the request cycle,
// loads take one extra cycle for the RAM read, and byte/half stores are done
// as read-modify-write over two extra cycles. The CPU is stalled while an
// access is in flight; misaligned or reserved-size requests are rejected
// with a one-cycle misalign_err pulse and cause no RAM traffic.
//
// Ports:
//   clock         in   1       system clock, rising edge
//   resetn        in   1       asynchronous active-low reset
//   req           in   1       access request (held stable while stall=1)
//   wr            in   1       1 = store, 0 = load
//   size          in   2       SZ_BYTE / SZ_HALF / SZ_WORD
//   sign_ext      in   1       load extension select
//   addr          in   32      byte address
//   wdata         in   32      store data
//   rdata         out  32      extended load result, valid when stall falls
//   stall         out  1       hold the PC / pipeline inputs
//   misalign_err  out  1       rejected-request pulse
//   mem_addr      out  ADDR_W  RAM word index (addr[ADDR_W+1:2])
//   mem_wdata     out  32      RAM write word
//   mem_we        out  1       RAM write enable
//   mem_rdata     in   32      RAM read word, valid the cycle after mem_addr
// ---------------------------------------------------------------------------
module sc_mem_access_unit
    import sc_mem_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    state_t      state;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;
    logic [31:0] load_val;
    logic [31:0] merged_word;

    logic idle_req;
    logic bad_req;
    logic good_req;
    logic is_word_store;

    // Upper address bits are deliberately ignored: the RAM index wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // Gating with resetn keeps stall/mem_we low for the whole reset window,
    // even if the CPU still holds a request.
    assign idle_req      = resetn && (state == IDLE) && req;
    assign bad_req       = idle_req && is_misaligned(size, addr[1:0]);
    assign good_req      = idle_req && !is_misaligned(size, addr[1:0]);
    assign is_word_store = wr && (size == SZ_WORD);

    // The same lane block serves both load extraction (LOAD_WAIT) and store
    // merging (RMW_READ); inputs are held stable by the CPU while stalled.
    sc_mem_lane u_lane (
        .word     (mem_rdata),
        .offset   (addr[1:0]),
        .size     (size),
        .sign_ext (sign_ext),
        .wdata    (wdata),
        .load_val (load_val),
        .merged   (merged_word)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            rdata_q <= '0;
            // NOTE: the merge buffer is a plain register, so it is reset like
            // any other state; only true RAM arrays are left unreset.
            merge_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (good_req) begin
                        if (!wr) begin
                            state <= LOAD_WAIT;
                        end else if (!is_word_store) begin
                            state <= RMW_READ;
                        end
                    end
                end
                LOAD_WAIT: begin
                    rdata_q <= load_val;
                    state   <= IDLE;
                end
                RMW_READ: begin
                    merge_q <= merged_word;
                    state   <= RMW_WRITE;
                end
                RMW_WRITE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr     = addr[ADDR_W+1:2];
    assign misalign_err = bad_req;
    assign stall        = (good_req && !is_word_store) || (state == RMW_READ);
    assign mem_we       = (good_req && is_word_store) || (state == RMW_WRITE);
    assign mem_wdata    = (state == RMW_WRITE) ? merge_q : wdata;

    // The load result is presented straight from the RAM in the completion
    // cycle and then held in rdata_q; a rejected request shows zero.
    always_comb begin
        rdata = rdata_q;
        if (bad_req) begin
            rdata = '0;
        end else if (state == LOAD_WAIT) begin
            rdata = load_val;
        end
    end

endmodule

// File: tb/tb_sc_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_sc_mem_access_unit
// Self-checking bench: a behavioural synchronous-read RAM, a table of access
// vectors with expected stall/write/error behaviour, a scoreboard queue of
// expected load results, and hand-written reset and back-to-back sequences.
// ---------------------------------------------------------------------------
module tb_sc_mem_access_unit;
    import sc_mem_pkg::*;

    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic [1:0]        size = SZ_WORD;
    logic              sign_ext = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              stall;
    logic              misalign_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    logic [31:0] ram [32];

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stall;
        int          exp_we;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    sb_t sb_q[$];

    sc_mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req          (req),
        .wr           (wr),
        .size         (size),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .misalign_err (misalign_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    // Word-wide RAM, synchronous read (read-before-write on the same index).
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic w,
                                input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input int es,
                                input int ew, input logic em);
        vec_t v;
        v.name = name; v.wr = w; v.size = sz; v.sx = sx; v.addr = a;
        v.wdata = d; v.exp_rdata = er; v.exp_stall = es; v.exp_we = ew;
        v.exp_mis = em;
        return v;
    endfunction

    // Drives one request at a falling edge and follows it until stall is low
    // in a sampled cycle (the completion cycle). Inputs stay held until the
    // next request or idle() so the DUT sees them stable while stalled.
    task automatic run_vec(input vec_t v);
        int                stall_cnt = 0;
        int                we_cnt = 0;
        logic              mis_seen = 1'b0;
        logic              done = 1'b0;
        logic [31:0]       got_rdata = '0;
        logic [ADDR_W-1:0] first_addr;
        logic [ADDR_W-1:0] exp_addr;
        sb_t               e;
        @(negedge clock);
        req = 1'b1; wr = v.wr; size = v.size; sign_ext = v.sx;
        addr = v.addr; wdata = v.wdata;
        if (!v.wr || v.exp_mis) begin
            e.name = v.name; e.val = v.exp_rdata;
            sb_q.push_back(e);
        end
        #1;
        first_addr = mem_addr;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clock);
                #1;
            end
            if (mem_we) we_cnt++;
            if (misalign_err) mis_seen = 1'b1;
            if (!stall) begin
                done = 1'b1;
                got_rdata = rdata;
                break;
            end
            stall_cnt++;
        end
        exp_addr = v.addr[ADDR_W+1:2];
        check({v.name, " done"}, 32'(done), 32'd1);
        check({v.name, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
        check({v.name, " mem_we_cycles"}, 32'(we_cnt), 32'(v.exp_we));
        check({v.name, " misalign_err"}, 32'(mis_seen), 32'(v.exp_mis));
        check({v.name, " mem_addr"}, 32'(first_addr), 32'(exp_addr));
        if (!v.wr || v.exp_mis) begin
            e = sb_q.pop_front();
            check({e.name, " rdata"}, got_rdata, e.val);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        req = 1'b0;
        #1;
        check("idle stall", 32'(stall), 32'd0);
        check("idle mem_we", 32'(mem_we), 32'd0);
        check("idle misalign_err", 32'(misalign_err), 32'd0);
    endtask

    initial begin
        vec_t tbl[$];

        // Setup stores, word store/load, byte/half loads, sub-word RMW,
        // rejected requests and address wrap-around.
        tbl.push_back(mk("sw_08",   1, SZ_WORD, 0, 32'h08, 32'hDEADBEEF, 32'h0,        0, 1, 0));
        tbl.push_back(mk("lw_08",   0, SZ_WORD, 0, 32'h08, 32'h0,        32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(mk("sw_10",   1, SZ_WORD, 0, 32'h10, 32'h80FF7F01, 32'h0,        0, 1, 0));
        tbl.push_back(mk("lb_13",   0, SZ_BYTE, 1, 32'h13, 32'h0,        32'hFFFFFF80, 1, 0, 0));
        tbl.push_back(mk("lbu_13",  0, SZ_BYTE, 0, 32'h13, 32'h0,        32'h00000080, 1, 0, 0));
        tbl.push_back(mk("lb_11",   0, SZ_BYTE, 1, 32'h11, 32'h0,        32'h0000007F, 1, 0, 0));
        tbl.push_back(mk("lh_12",   0, SZ_HALF, 1, 32'h12, 32'h0,        32'hFFFF80FF, 1, 0, 0));
        tbl.push_back(mk("lhu_10",  0, SZ_HALF, 0, 32'h10, 32'h0,        32'h00007F01, 1, 0, 0));
        tbl.push_back(mk("sw_04",   1, SZ_WORD, 0, 32'h04, 32'h11223344, 32'h0,        0, 1, 0));
        tbl.push_back(mk("sh_06",   1, SZ_HALF, 0, 32'h06, 32'h5555ABCD, 32'h0,        2, 1, 0));
        tbl.push_back(mk("lw_04",   0, SZ_WORD, 0, 32'h04, 32'h0,        32'hABCD3344, 1, 0, 0));
        tbl.push_back(mk("sw_00",   1, SZ_WORD, 0, 32'h00, 32'h03020100, 32'h0,        0, 1, 0));
        tbl.push_back(mk("sw_0c",   1, SZ_WORD, 0, 32'h0C, 32'hCAFEF00D, 32'h0,        0, 1, 0));
        tbl.push_back(mk("lh_05",   0, SZ_HALF, 1, 32'h05, 32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(mk("sw_02",   1, SZ_WORD, 0, 32'h02, 32'hFFFFFFFF, 32'h0,        0, 0, 1));
        tbl.push_back(mk("rsv_00",  0, 2'b11,   0, 32'h00, 32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(mk("lw_wrap", 0, SZ_WORD, 0, 32'h80000088, 32'h0,  32'hDEADBEEF, 1, 0, 0));

        // Reset state, with a request held during reset.
        req = 1'b1; wr = 1'b0; size = SZ_WORD; addr = 32'h08;
        repeat (2) @(negedge clock);
        #1;
        check("reset rdata", rdata, 32'h0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset misalign_err", 32'(misalign_err), 32'd0);
        @(negedge clock);
        req = 1'b0;
        resetn = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);
        idle();
        check("ram[0] after rejected sw", ram[0], 32'h03020100);
        check("ram[1] after sh", ram[1], 32'hABCD3344);

        // Back-to-back: load, byte store, load with no idle cycles between.
        run_vec(mk("b2b_lw_00a", 0, SZ_WORD, 0, 32'h00, 32'h0,        32'h03020100, 1, 0, 0));
        run_vec(mk("b2b_sb_01",  1, SZ_BYTE, 0, 32'h01, 32'h12345655, 32'h0,        2, 1, 0));
        run_vec(mk("b2b_lw_00b", 0, SZ_WORD, 0, 32'h00, 32'h0,        32'h03025500, 1, 0, 0));
        idle();

        // Reset while a byte store is in RMW_READ: the write must be dropped.
        @(negedge clock);
        req = 1'b1; wr = 1'b1; size = SZ_BYTE; sign_ext = 1'b0;
        addr = 32'h0C; wdata = 32'h000000EE;
        #1;
        check("rst_rmw stall in idle", 32'(stall), 32'd1);
        @(negedge clock);
        #1;
        check("rst_rmw stall in read", 32'(stall), 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_rmw stall", 32'(stall), 32'd0);
        check("rst_rmw mem_we", 32'(mem_we), 32'd0);
        check("rst_rmw rdata", rdata, 32'h0);
        @(negedge clock);
        req = 1'b0;
        resetn = 1'b1;
        #1;
        check("rst_rmw ram word", ram[3], 32'hCAFEF00D);
        check("rst_rmw rdata after", rdata, 32'h0);
        run_vec(mk("rst_lw_0c", 0, SZ_WORD, 0, 32'h0C, 32'h0, 32'hCAFEF00D, 1, 0, 0));
        idle();

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
